// File: rtl/alu_seq_exec.sv
// rtl/alu_seq_exec.sv - sequential EX-stage ALU with iterative shifter
//
// Purpose : accepts one ALU operation per In_valid/In_ready handshake.
//           Add/sub/compare/logic complete in one cycle. Shifts step one bit
//           per cycle. The result is held until Out_ready is asserted.
// Config  : ALU_SEQ_FAST_SHIFT_EN -- when defined, shifts use a barrel shifter
//           and take the single-cycle path; the SHIFT state and counter vanish.
// Ports   : CLK, RESET_N (async, active-low)
//           In_valid/In_ready        operation handshake
//           ALUsel[7:0], UseImm      decoded op and immediate select
//           A, B, Imm [31:0], Shamt  operands
//           Out_valid/Out_ready      result handshake
//           Result[31:0], Ovf, Illegal
module alu_seq_exec (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        In_valid,
  output logic        In_ready,
  input  logic [7:0]  ALUsel,
  input  logic        UseImm,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [31:0] Imm,
  input  logic [4:0]  Shamt,
  output logic        Out_valid,
  input  logic        Out_ready,
  output logic [31:0] Result,
  output logic        Ovf,
  output logic        Illegal
);

  // select_alu_* codes shared with instruction decode (dlx_defs.v).
  // 8'h00 and 8'hFF are deliberately unused so undriven buses decode illegal.
  localparam logic [7:0] SEL_ADD  = 8'h01;
  localparam logic [7:0] SEL_SUB  = 8'h02;
  localparam logic [7:0] SEL_SLT  = 8'h03;
  localparam logic [7:0] SEL_SLTU = 8'h04;
  localparam logic [7:0] SEL_AND  = 8'h05;
  localparam logic [7:0] SEL_OR   = 8'h06;
  localparam logic [7:0] SEL_XOR  = 8'h07;
  localparam logic [7:0] SEL_NOR  = 8'h08;
  localparam logic [7:0] SEL_SLL  = 8'h09;
  localparam logic [7:0] SEL_SRL  = 8'h0A;
  localparam logic [7:0] SEL_SRA  = 8'h0B;

`ifdef ALU_SEQ_FAST_SHIFT_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_DONE = 2'd2} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_DONE = 2'd2} state_t;

  localparam logic [1:0] KIND_SLL = 2'd0;
  localparam logic [1:0] KIND_SRL = 2'd1;
  localparam logic [1:0] KIND_SRA = 2'd2;

  logic [31:0] r_shreg;
  logic [4:0]  r_cnt;
  logic [1:0]  r_shkind;
  logic        w_is_shift;
  logic [1:0]  w_shkind;
  logic [31:0] w_step;
`endif

  state_t      r_state;
  logic [31:0] r_result;
  logic        r_ovf;
  logic        r_ill;

  logic [31:0] w_op2;
  logic [4:0]  w_amt;
  logic [31:0] w_sum;
  logic [31:0] w_diff;
  logic [31:0] w_res;
  logic        w_ovf;
  logic        w_ill;
  logic        w_accept;

  assign w_op2    = UseImm ? Imm : B;
  assign w_amt    = UseImm ? Shamt : A[4:0];
  assign w_sum    = A + w_op2;
  assign w_diff   = A - w_op2;

  assign Out_valid = (r_state == ST_DONE);
  assign In_ready  = (r_state == ST_IDLE) | ((r_state == ST_DONE) & Out_ready);
  assign w_accept  = In_valid & In_ready;
  assign Result    = r_result;
  assign Ovf       = r_ovf;
  assign Illegal   = r_ill;

  // Single-cycle result for the accepted op. Plain case (not casez) so any
  // x/z bit on ALUsel falls through to the illegal default.
  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    w_ill = 1'b0;
`ifndef ALU_SEQ_FAST_SHIFT_EN
    w_is_shift = 1'b0;
    w_shkind   = KIND_SLL;
`endif
    case (ALUsel)
      SEL_ADD: begin
        w_res = w_sum;
        w_ovf = (A[31] == w_op2[31]) && (w_sum[31] != A[31]);
      end
      SEL_SUB: begin
        w_res = w_diff;
        w_ovf = (A[31] != w_op2[31]) && (w_diff[31] != A[31]);
      end
      SEL_SLT:  w_res = {31'd0, $signed(A) < $signed(w_op2)};
      SEL_SLTU: w_res = {31'd0, A < w_op2};
      SEL_AND:  w_res = A & w_op2;
      SEL_OR:   w_res = A | w_op2;
      SEL_XOR:  w_res = A ^ w_op2;
      SEL_NOR:  w_res = ~(A | w_op2);
`ifdef ALU_SEQ_FAST_SHIFT_EN
      SEL_SLL:  w_res = B << w_amt;
      SEL_SRL:  w_res = B >> w_amt;
      SEL_SRA:  w_res = $signed(B) >>> w_amt;
`else
      // Shift by zero completes immediately with the unshifted value.
      SEL_SLL: begin w_res = B; w_is_shift = 1'b1; w_shkind = KIND_SLL; end
      SEL_SRL: begin w_res = B; w_is_shift = 1'b1; w_shkind = KIND_SRL; end
      SEL_SRA: begin w_res = B; w_is_shift = 1'b1; w_shkind = KIND_SRA; end
`endif
      default:  w_ill = 1'b1;
    endcase
  end

`ifndef ALU_SEQ_FAST_SHIFT_EN
  always_comb begin
    case (r_shkind)
      KIND_SLL: w_step = {r_shreg[30:0], 1'b0};
      KIND_SRL: w_step = {1'b0, r_shreg[31:1]};
      default:  w_step = {r_shreg[31], r_shreg[31:1]};
    endcase
  end
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state  <= ST_IDLE;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_ill    <= 1'b0;
`ifndef ALU_SEQ_FAST_SHIFT_EN
      r_shreg  <= '0;
      r_cnt    <= '0;
      r_shkind <= KIND_SLL;
`endif
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept) begin
`ifndef ALU_SEQ_FAST_SHIFT_EN
            if (w_is_shift && (w_amt != 5'd0)) begin
              r_shreg  <= B;
              r_cnt    <= w_amt;
              r_shkind <= w_shkind;
              r_state  <= ST_SHIFT;
            end else
`endif
            begin
              r_result <= w_res;
              r_ovf    <= w_ovf;
              r_ill    <= w_ill;
              r_state  <= ST_DONE;
            end
          end else if ((r_state == ST_DONE) && Out_ready) begin
            r_state <= ST_IDLE;
          end
        end
`ifndef ALU_SEQ_FAST_SHIFT_EN
        // One bit per cycle while the counter is non-zero; the cycle after it
        // empties moves the shifted value into the result register.
        ST_SHIFT: begin
          if (r_cnt != 5'd0) begin
            r_shreg <= w_step;
            r_cnt   <= r_cnt - 5'd1;
          end else begin
            r_result <= r_shreg;
            r_ovf    <= 1'b0;
            r_ill    <= 1'b0;
            r_state  <= ST_DONE;
          end
        end
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_exec.sv
// tb/tb_alu_seq_exec.sv - randomized self-checking bench for alu_seq_exec
module tb_alu_seq_exec;

  localparam logic [7:0] C_ADD  = 8'h01;
  localparam logic [7:0] C_SUB  = 8'h02;
  localparam logic [7:0] C_SLT  = 8'h03;
  localparam logic [7:0] C_SLTU = 8'h04;
  localparam logic [7:0] C_AND  = 8'h05;
  localparam logic [7:0] C_OR   = 8'h06;
  localparam logic [7:0] C_XOR  = 8'h07;
  localparam logic [7:0] C_NOR  = 8'h08;
  localparam logic [7:0] C_SLL  = 8'h09;
  localparam logic [7:0] C_SRL  = 8'h0A;
  localparam logic [7:0] C_SRA  = 8'h0B;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        In_valid = 1'b0;
  logic        In_ready;
  logic [7:0]  ALUsel = 8'h00;
  logic        UseImm = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [31:0] Imm = '0;
  logic [4:0]  Shamt = '0;
  logic        Out_valid;
  logic        Out_ready = 1'b0;
  logic [31:0] Result;
  logic        Ovf;
  logic        Illegal;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_on  = 0;
  bit rand_on = 0;

  always #5 CLK = ~CLK;

  alu_seq_exec dut (
    .CLK(CLK), .RESET_N(RESET_N), .In_valid(In_valid), .In_ready(In_ready),
    .ALUsel(ALUsel), .UseImm(UseImm), .A(A), .B(B), .Imm(Imm), .Shamt(Shamt),
    .Out_valid(Out_valid), .Out_ready(Out_ready), .Result(Result),
    .Ovf(Ovf), .Illegal(Illegal)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: what an op must produce and how many edges after acceptance
  // the result becomes visible.
  function automatic void model_op(input logic [7:0] sel, input logic ui,
                                   input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] imm, input logic [4:0] sh,
                                   output logic [31:0] res, output logic ovf,
                                   output logic ill, output int lat);
    logic [31:0] op2;
    int          amt;
    longint      sa, sb, s;
    op2 = ui ? imm : b;
    amt = ui ? int'(sh) : int'(a[4:0]);
    sa  = $signed(a);
    sb  = $signed(op2);
    res = '0; ovf = 1'b0; ill = 1'b0; lat = 1;
    case (sel)
      C_ADD:  begin s = sa + sb; res = s[31:0]; ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      C_SUB:  begin s = sa - sb; res = s[31:0]; ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      C_SLT:  res = (sa < sb) ? 32'd1 : 32'd0;
      C_SLTU: res = (a < op2) ? 32'd1 : 32'd0;
      C_AND:  res = a & op2;
      C_OR:   res = a | op2;
      C_XOR:  res = a ^ op2;
      C_NOR:  res = ~(a | op2);
      C_SLL:  begin res = b << amt; lat = shift_lat(amt); end
      C_SRL:  begin res = b >> amt; lat = shift_lat(amt); end
      C_SRA:  begin res = $signed(b) >>> amt; lat = shift_lat(amt); end
      default: ill = 1'b1;
    endcase
  endfunction

  function automatic int shift_lat(input int amt);
`ifdef ALU_SEQ_FAST_SHIFT_EN
    return 1;
`else
    return (amt == 0) ? 1 : amt + 1;
`endif
  endfunction

  // Transaction-level model: one op in flight at most, a countdown until its
  // result shows up, and a held result until it is taken.
  bit          m_valid = 0;
  int          m_pend  = 0;
  bit          m_acc   = 0;
  logic [31:0] m_res = '0, p_res = '0;
  logic        m_ovf = 0, m_ill = 0, p_ovf = 0, p_ill = 0;
  wire         exp_ready = (m_pend == 0) && (!m_valid || Out_ready);

  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      m_valid = 0; m_pend = 0; m_acc = 0;
    end else begin
      logic [31:0] r; logic o, il; int lat; bit acc;
      acc   = In_valid && exp_ready;
      m_acc = acc;
      if (m_pend > 0) begin
        m_pend--;
        if (m_pend == 0) begin m_valid = 1; m_res = p_res; m_ovf = p_ovf; m_ill = p_ill; end
      end else if (m_valid && Out_ready) begin
        m_valid = 0;
      end
      if (acc) begin
        model_op(ALUsel, UseImm, A, B, Imm, Shamt, r, o, il, lat);
        if (lat == 1) begin m_valid = 1; m_res = r; m_ovf = o; m_ill = il; end
        else begin m_valid = 0; m_pend = lat; p_res = r; p_ovf = o; p_ill = il; end
      end
    end
  end

  always @(negedge CLK) begin
    if (RESET_N && cmp_on) begin
      chk("out_valid", Out_valid, m_valid);
      chk("in_ready", In_ready, exp_ready);
      if (m_valid) begin
        chk("result", Result, m_res);
        chk("ovf", Ovf, m_ovf);
        chk("illegal", Illegal, m_ill);
      end
    end
  end

  task automatic issue(input logic [7:0] sel, input logic ui, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] imm, input logic [4:0] sh);
    bit done = 0;
    ALUsel = sel; UseImm = ui; A = a; B = b; Imm = imm; Shamt = sh;
    In_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge CLK); #1;
      if (m_acc) done = 1;
    end
    In_valid = 1'b0;
    chk("issue_accepted", done, 1);
  endtask

  task automatic run_lit(input string name, input logic [7:0] sel, input logic ui,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                         input logic [4:0] sh, input logic [31:0] e_res, input logic e_ovf,
                         input logic e_ill, input int e_lat);
    int lat = 0;
    bit seen = 0;
    Out_ready = 1'b0;
    issue(sel, ui, a, b, imm, sh);
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge CLK); #1;
      lat++;
      if (Out_valid === 1'b1) seen = 1;
    end
    chk({name, "_seen"}, seen, 1);
    chk({name, "_latency"}, lat, e_lat);
    chk({name, "_result"}, Result, e_res);
    chk({name, "_ovf"}, Ovf, e_ovf);
    chk({name, "_illegal"}, Illegal, e_ill);
    Out_ready = 1'b1;
    @(posedge CLK); #1;
    Out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] r; logic o, il; int lat;
    logic [7:0] codes [11];
    int sra_lat, stale;
    bit seen;
    codes = '{C_ADD, C_SUB, C_SLT, C_SLTU, C_AND, C_OR, C_XOR, C_NOR, C_SLL, C_SRL, C_SRA};
`ifdef ALU_SEQ_FAST_SHIFT_EN
    sra_lat = 1;
`else
    sra_lat = 5;
`endif

    // Pin the reference model against hand-computed values.
    model_op(C_ADD, 0, 32'h7FFFFFFF, 32'h1, 0, 0, r, o, il, lat);
    chk("model_add_res", r, 32'h80000000); chk("model_add_ovf", o, 1);
    model_op(C_SUB, 1, 32'd5, 0, 32'hFFFFFFFF, 0, r, o, il, lat);
    chk("model_sub_res", r, 32'd6); chk("model_sub_ovf", o, 0);
    model_op(C_SUB, 0, 32'h80000000, 32'h1, 0, 0, r, o, il, lat);
    chk("model_sub2_res", r, 32'h7FFFFFFF); chk("model_sub2_ovf", o, 1);
    model_op(C_SLTU, 0, 32'hFFFFFFFF, 32'h1, 0, 0, r, o, il, lat);
    chk("model_sltu", r, 32'd0);
    model_op(C_SLT, 0, 32'hFFFFFFFF, 32'h1, 0, 0, r, o, il, lat);
    chk("model_slt", r, 32'd1);
    model_op(C_SRA, 1, 0, 32'h80000010, 0, 5'd4, r, o, il, lat);
    chk("model_sra_res", r, 32'hF8000001); chk("model_sra_lat", lat, sra_lat);
    model_op(C_NOR, 0, 0, 0, 0, 0, r, o, il, lat);
    chk("model_nor", r, 32'hFFFFFFFF);

    // Reset values.
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_out_valid", Out_valid, 0);
    chk("rst_result", Result, 0);
    chk("rst_ovf", Ovf, 0);
    chk("rst_illegal", Illegal, 0);
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    @(negedge CLK);
    chk("rst_in_ready", In_ready, 1);
    cmp_on = 1;
    @(posedge CLK); #1;

    // Directed cases.
    run_lit("add_ovf", C_ADD, 0, 32'h7FFFFFFF, 32'h1, 0, 0, 32'h80000000, 1, 0, 1);
    run_lit("sub_imm", C_SUB, 1, 32'd5, 32'h0, 32'hFFFFFFFF, 0, 32'd6, 0, 0, 1);
    run_lit("sltu", C_SLTU, 0, 32'hFFFFFFFF, 32'h1, 0, 0, 32'd0, 0, 0, 1);
    run_lit("slt", C_SLT, 0, 32'hFFFFFFFF, 32'h1, 0, 0, 32'd1, 0, 0, 1);
    run_lit("sra4", C_SRA, 1, 32'h0, 32'h80000010, 0, 5'd4, 32'hF8000001, 0, 0, sra_lat);
    run_lit("sllv0", C_SLL, 0, 32'h0, 32'hA5A5_1234, 0, 5'd7, 32'hA5A5_1234, 0, 0, 1);
    run_lit("lui_or", C_OR, 1, 32'h0, 32'h0, 32'h1234_0000, 0, 32'h1234_0000, 0, 0, 1);
    run_lit("illegal_x", 8'hxx, 0, 32'h1, 32'h2, 0, 0, 32'd0, 0, 1, 1);
    run_lit("illegal_ff", 8'hFF, 0, 32'h1, 32'h2, 0, 0, 32'd0, 0, 1, 1);

    // Backpressure then back-to-back accept.
    Out_ready = 1'b0;
    issue(C_ADD, 0, 32'd1, 32'd2, 0, 0);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (Out_valid === 1'b1) seen = 1;
      else begin @(posedge CLK); #1; end
    end
    chk("bp_seen", seen, 1);
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK); #1;
      chk("bp_result_stable", Result, 32'd3);
      chk("bp_in_ready", In_ready, 0);
    end
    ALUsel = C_ADD; UseImm = 0; A = 32'd10; B = 32'd20;
    In_valid = 1'b1; Out_ready = 1'b1;
    @(posedge CLK); #1;
    In_valid = 1'b0;
    chk("b2b_out_valid", Out_valid, 1);
    chk("b2b_result", Result, 32'd30);
    @(posedge CLK); #1;
    Out_ready = 1'b0;

    // Randomized traffic with random downstream backpressure.
    rand_on = 1;
    fork
      begin
        for (int k = 0; k < 300; k++) begin
          logic [7:0] sel;
          sel = ($urandom_range(0, 15) == 0) ? 8'($urandom) : codes[$urandom_range(0, 10)];
          issue(sel, 1'($urandom), $urandom, $urandom, $urandom, 5'($urandom));
          repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
        end
        rand_on = 0;
      end
      begin
        while (rand_on) begin
          @(posedge CLK); #1;
          Out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    Out_ready = 1'b1;
    repeat (40) begin @(posedge CLK); #1; end
    Out_ready = 1'b0;

    // Reset in the middle of a long shift discards the op.
    issue(C_SLL, 1, 32'h0, 32'h1, 0, 5'd31);
    repeat (5) begin @(posedge CLK); #1; end
    RESET_N = 1'b0;
    #1;
    chk("midrst_out_valid", Out_valid, 0);
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    @(negedge CLK);
    chk("midrst_release_out_valid", Out_valid, 0);
    chk("midrst_release_in_ready", In_ready, 1);
    stale = 0;
    repeat (40) begin
      @(negedge CLK);
      if (Out_valid !== 1'b0) stale++;
    end
    chk("midrst_no_stale", stale, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
